// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port data memory between the core (port 0, priority)
// and the loader/DMA path (port 1), with a starvation bound and one registered response.
module data_mem_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_resp_valid,
  output logic [DATA_WIDTH-1:0] p0_resp_rdata,
  output logic                  p0_resp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_write,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_resp_valid,
  output logic [DATA_WIDTH-1:0] p1_resp_rdata,
  output logic                  p1_resp_err,
  output logic                  mem_write_ctrl,
  output logic                  mem_read_ctrl,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | nothing was accepted last cycle, no response presented
  // ISSUE | a request was accepted last cycle, its response is presented now
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state, state_next;
  logic [3:0]            wait_cnt, wait_cnt_next;
  logic                  force_p1, gnt_p0, gnt_p1;
  logic                  sel_write, misaligned;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  resp_port, resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  assign force_p1 = (wait_cnt == LIMIT);

  always_comb begin
    gnt_p0 = 1'b0;
    gnt_p1 = 1'b0;
    if (force_p1 && p1_req_valid) gnt_p1 = 1'b1;
    else if (p0_req_valid)        gnt_p0 = 1'b1;
    else if (p1_req_valid)        gnt_p1 = 1'b1;
  end

  assign p0_req_ready = gnt_p0;
  assign p1_req_ready = gnt_p1;

  always_comb begin
    sel_write = p0_req_write;
    sel_addr  = p0_req_addr;
    sel_wdata = p0_req_wdata;
    if (gnt_p1) begin
      sel_write = p1_req_write;
      sel_addr  = p1_req_addr;
      sel_wdata = p1_req_wdata;
    end
  end

  assign misaligned = (sel_addr[2:0] != 3'b000);

  always_comb begin
    state_next     = (gnt_p0 || gnt_p1) ? ISSUE : IDLE;
    mem_write_ctrl = 1'b0;
    mem_read_ctrl  = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    // Misaligned grants are acknowledged but never reach the memory.
    if (state_next == ISSUE && !misaligned) begin
      mem_write_ctrl = sel_write;
      mem_read_ctrl  = !sel_write;
      mem_addr       = sel_addr;
      mem_wdata      = sel_wdata;
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!p1_req_valid || gnt_p1) wait_cnt_next = 4'd0;
    else if (wait_cnt != LIMIT)  wait_cnt_next = wait_cnt + 4'd1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      resp_port  <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (state_next == ISSUE) begin
      resp_port  <= gnt_p1;
      resp_err   <= misaligned;
      resp_rdata <= (!misaligned && !sel_write) ? mem_rdata : '0;
    end
  end

  assign p0_resp_valid = (state == ISSUE) && !resp_port;
  assign p1_resp_valid = (state == ISSUE) && resp_port;
  assign p0_resp_err   = p0_resp_valid && resp_err;
  assign p1_resp_err   = p1_resp_valid && resp_err;
  assign p0_resp_rdata = p0_resp_valid ? resp_rdata : '0;
  assign p1_resp_rdata = p1_resp_valid ? resp_rdata : '0;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port, word-addressed data memory between the core load/store path (port 0) and the program loader / debug DMA path (port 1). Port 0 has fixed priority; a wait counter guarantees port 1 a grant after a bounded stall. At most one access is issued to the memory per cycle. Each accepted request gets exactly one registered response one cycle later, and misaligned requests are rejected without touching memory.

## Interface
- DATA_WIDTH, 64, word width in bits
- ADDR_WIDTH, 64, byte address width
- STARVE_LIMIT, 4, consecutive cycles port 1 may wait with valid high before it is forced to win (1..15)
- clk_in  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- p0_req_valid, p1_req_valid  input  1  request present
- p0_req_ready, p1_req_ready  output  1  request accepted this cycle (combinational grant)
- p0_req_write, p1_req_write  input  1  1 = store word, 0 = load word
- p0_req_addr, p1_req_addr  input  ADDR_WIDTH  byte address
- p0_req_wdata, p1_req_wdata  input  DATA_WIDTH  store data
- p0_resp_valid, p1_resp_valid  output  1  one-cycle response strobe
- p0_resp_rdata, p1_resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors
- p0_resp_err, p1_resp_err  output  1  misaligned address, qualified by resp_valid
- mem_write_ctrl  output  1  to memory write enable
- mem_read_ctrl  output  1  to memory read enable
- mem_addr  output  ADDR_WIDTH  to memory address
- mem_wdata  output  DATA_WIDTH  to memory write data
- mem_rdata  input  DATA_WIDTH  from memory asynchronous read data

## Operation
- Grant, evaluated combinationally each cycle:
  - If force_p1 is set and p1_req_valid: grant port 1.
  - Else if p0_req_valid: grant port 0.
  - Else if p1_req_valid: grant port 1.
  - Else: no grant.
- req_ready is high only for the granted port. Requests follow valid/ready semantics: a requester holds valid and its payload stable until ready.
- Alignment check: the granted request is misaligned when addr[2:0] != 0. A misaligned request is still accepted (ready=1), but mem_write_ctrl and mem_read_ctrl stay 0 and the response carries err=1 with rdata=0.
- Memory drive for an aligned grant: mem_addr and mem_wdata take the granted payload. The granted write flag selects mem_write_ctrl; its inverse selects mem_read_ctrl. With no grant, all mem_* outputs are 0.
- Starvation counter wait_cnt (4 bits):
  - Increments when p1_req_valid is high and port 1 is not granted.
  - Clears when port 1 is granted or p1_req_valid is low.
  - Saturates at STARVE_LIMIT.
  - force_p1 = (wait_cnt == STARVE_LIMIT).
- Response register: on an accepted request, the arbiter captures the port id, err, and rdata on the clock edge. rdata is mem_rdata for an aligned read, else 0.
- Request state machine, per cycle: IDLE (no grant) / ISSUE (grant). There is no multi-cycle state and no outstanding-transaction limit beyond one response in flight.

## Timing
- Accepted in cycle N gives resp_valid for the same port in cycle N+1, high for exactly one cycle. Back-to-back accepts produce back-to-back responses.
- A store commits in memory at the posedge ending cycle N. A load issued in cycle N+1 to the same address returns the new data.
- No response backpressure: requesters must sample resp_* in the cycle resp_valid is high.
- Simultaneous valid on both ports with wait_cnt < STARVE_LIMIT: port 0 wins and wait_cnt increments.
- Once wait_cnt reaches the limit, port 1 wins the next cycle regardless of port 0. Port 0 then waits exactly one cycle.
- Reset (asynchronous, any time, including mid-transaction):
  - All resp_valid, resp_err, resp_rdata, and wait_cnt go to 0 immediately.
  - A request granted in the cycle reset asserts produces no response.
  - Memory contents are not affected by this block.
- After reset release, the first clock edge already accepts requests.

## Test plan
- Port 0 only: write 0xDEADBEEF_00000001 to addr 0x10, then read 0x10. Expect ready in cycles 0 and 1, a write ack (rdata=0, err=0) in cycle 1, and read data 0xDEADBEEF_00000001 in cycle 2.
- Both ports valid continuously with STARVE_LIMIT=4: grants go p0 ×4, then p1, then p0 ×4, then p1. Confirm wait_cnt saturates at 4 and clears on the port 1 grant.
- Port 1 read of addr 0x0C (misaligned): ready=1, mem_read_ctrl=0, and next cycle p1_resp_valid=1, err=1, rdata=0.
- Port 1 writes 0x55 to 0x20 in cycle 0 while port 0 reads 0x20 in cycle 1: port 0 receives 0x55 in cycle 2.
- Assert reset_n=0 asynchronously mid-cycle after a granted read: resp_valid drops immediately, no response appears after release, and the next request completes normally.
- Idle with no valids for 10 cycles: all mem_* outputs are 0, no resp_valid, and wait_cnt stays 0.
